// File: rtl/gshare_index_gen_pkg.sv
// Shared sizing for the gshare index generator and the PHT core it feeds.
package gshare_index_gen_pkg;

  localparam int unsigned PHT_BITS_DEF = 10;
  localparam int unsigned GHR_BITS_DEF = 8;
  localparam int unsigned PC_LSB_DEF   = 2;
  localparam int unsigned PC_BITS      = 32;
  localparam int unsigned CNT_BITS     = 32;
  localparam int unsigned SLOT_STRIDE  = 4;

endpackage

// File: rtl/gshare_index_gen_if.sv
// Fetch-side, resolve-side and PHT correct-port signals of the gshare index generator.
interface gshare_index_gen_if
  import gshare_index_gen_pkg::*;
#(
  parameter int unsigned PHT_BITS = PHT_BITS_DEF,
  parameter int unsigned GHR_BITS = GHR_BITS_DEF
);

  logic [PC_BITS-1:0]  fetch_pc;
  logic [PHT_BITS-1:0] search_index1;
  logic [PHT_BITS-1:0] search_index2;
  logic [GHR_BITS-1:0] ghr_snapshot;
  logic                pred_valid1;
  logic                pred_taken1;
  logic                pred_valid2;
  logic                pred_taken2;
  logic                ex_valid;
  logic [PC_BITS-1:0]  ex_pc;
  logic [GHR_BITS-1:0] ex_ghr;
  logic                ex_taken;
  logic                ex_mispredict;
  logic                flush;
  logic                corr_valid;
  logic [PHT_BITS-1:0] corr_index;
  logic                corr_branch_flag;
  logic [CNT_BITS-1:0] mispredict_cnt;

  modport master (
    output fetch_pc, pred_valid1, pred_taken1, pred_valid2, pred_taken2,
           ex_valid, ex_pc, ex_ghr, ex_taken, ex_mispredict, flush,
    input  search_index1, search_index2, ghr_snapshot,
           corr_valid, corr_index, corr_branch_flag, mispredict_cnt
  );

  modport slave (
    input  fetch_pc, pred_valid1, pred_taken1, pred_valid2, pred_taken2,
           ex_valid, ex_pc, ex_ghr, ex_taken, ex_mispredict, flush,
    output search_index1, search_index2, ghr_snapshot,
           corr_valid, corr_index, corr_branch_flag, mispredict_cnt
  );

endinterface

// File: rtl/gshare_index_gen_hash.sv
// Combinational gshare hash: PC index field XOR zero-extended history.
module gshare_hash
  import gshare_index_gen_pkg::*;
#(
  parameter int unsigned PHT_BITS = PHT_BITS_DEF,
  parameter int unsigned GHR_BITS = GHR_BITS_DEF,
  parameter int unsigned PC_LSB   = PC_LSB_DEF
) (
  input  logic [PC_BITS-1:0]  pc,
  input  logic [GHR_BITS-1:0] h,
  output logic [PHT_BITS-1:0] idx
);

  logic unused_pc_bits;

  assign idx            = pc[PC_LSB +: PHT_BITS] ^ PHT_BITS'(h);
  assign unused_pc_bits = &{1'b0, pc};

endmodule

// File: rtl/gshare_index_gen.sv
// Speculative/architectural global history, gshare search and correct-port indices,
// and a saturating mispredict counter.
module gshare_index_gen
  import gshare_index_gen_pkg::*;
#(
  parameter int unsigned PHT_BITS = PHT_BITS_DEF,
  parameter int unsigned GHR_BITS = GHR_BITS_DEF,
  parameter int unsigned PC_LSB   = PC_LSB_DEF
) (
  input logic              clk,
  input logic              rst,
  gshare_index_gen_if.slave bus
);

  logic [GHR_BITS-1:0] spec_ghr;
  logic [GHR_BITS-1:0] arch_ghr;
  logic [GHR_BITS-1:0] spec_next;
  logic [GHR_BITS-1:0] arch_next;
  logic [PC_BITS-1:0]  fetch_pc2;
  logic [PHT_BITS-1:0] corr_index_next;
  logic                corr_valid_q;
  logic [PHT_BITS-1:0] corr_index_q;
  logic                corr_flag_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                mispredict;

  assign fetch_pc2  = bus.fetch_pc + PC_BITS'(SLOT_STRIDE);
  assign mispredict = bus.ex_valid && bus.ex_mispredict;

  gshare_hash #(.PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS), .PC_LSB(PC_LSB)) u_hash_s1 (
    .pc(bus.fetch_pc), .h(spec_ghr), .idx(bus.search_index1)
  );

  gshare_hash #(.PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS), .PC_LSB(PC_LSB)) u_hash_s2 (
    .pc(fetch_pc2), .h(spec_ghr), .idx(bus.search_index2)
  );

  gshare_hash #(.PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS), .PC_LSB(PC_LSB)) u_hash_ex (
    .pc(bus.ex_pc), .h(bus.ex_ghr), .idx(corr_index_next)
  );

  // Shifts truncate {history, new bits} to GHR_BITS, so GHR_BITS=1 keeps only the newest bit.
  always_comb begin
    arch_next = arch_ghr;
    if (bus.ex_valid) arch_next = GHR_BITS'({arch_ghr, bus.ex_taken});

    spec_next = spec_ghr;
    if (bus.flush)
      spec_next = arch_next;
    else if (mispredict)
      spec_next = GHR_BITS'({bus.ex_ghr, bus.ex_taken});
    else if (bus.pred_valid1 && bus.pred_taken1)
      spec_next = GHR_BITS'({spec_ghr, 1'b1});
    else if (bus.pred_valid1 && bus.pred_valid2)
      spec_next = GHR_BITS'({spec_ghr, 1'b0, bus.pred_taken2});
    else if (bus.pred_valid1)
      spec_next = GHR_BITS'({spec_ghr, bus.pred_taken1});
    else if (bus.pred_valid2)
      spec_next = GHR_BITS'({spec_ghr, bus.pred_taken2});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr     <= '0;
      arch_ghr     <= '0;
      corr_valid_q <= 1'b0;
      corr_index_q <= '0;
      corr_flag_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      spec_ghr     <= spec_next;
      arch_ghr     <= arch_next;
      corr_valid_q <= bus.ex_valid;
      corr_index_q <= corr_index_next;
      corr_flag_q  <= bus.ex_taken;
      if (mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  assign bus.ghr_snapshot     = spec_ghr;
  assign bus.corr_valid       = corr_valid_q;
  assign bus.corr_index       = corr_index_q;
  assign bus.corr_branch_flag = corr_flag_q;
  assign bus.mispredict_cnt   = cnt_q;

endmodule

// File: tb/tb_gshare_index_gen.sv
// Directed self-checking bench for gshare_index_gen with hand-computed expectations.
module tb_gshare_index_gen;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gshare_index_gen_if bus ();

  gshare_index_gen dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.pred_valid1   = 1'b0;
    bus.pred_taken1   = 1'b0;
    bus.pred_valid2   = 1'b0;
    bus.pred_taken2   = 1'b0;
    bus.ex_valid      = 1'b0;
    bus.ex_pc         = 32'h0;
    bus.ex_ghr        = 8'h00;
    bus.ex_taken      = 1'b0;
    bus.ex_mispredict = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [7:0] h, input logic t, input logic mp);
    bus.ex_valid      = 1'b1;
    bus.ex_pc         = pc;
    bus.ex_ghr        = h;
    bus.ex_taken      = t;
    bus.ex_mispredict = mp;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.fetch_pc = 32'h0000_1000;
    clr_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_idx1", 32'(bus.search_index1), 32'h000);
    check("rst_idx2", 32'(bus.search_index2), 32'h001);
    check("rst_ghr", 32'(bus.ghr_snapshot), 32'h00);
    check("rst_cvalid", 32'(bus.corr_valid), 32'h0);
    check("rst_cindex", 32'(bus.corr_index), 32'h000);
    check("rst_cflag", 32'(bus.corr_branch_flag), 32'h0);
    check("rst_cnt", bus.mispredict_cnt, 32'h0);

    // Two-slot shift {0,1}, then slot-1 taken
    bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b0;
    bus.pred_valid2 = 1'b1; bus.pred_taken2 = 1'b1;
    step(); clr_in();
    check("pair_ghr", 32'(bus.ghr_snapshot), 32'h01);
    bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b1;
    bus.pred_valid2 = 1'b1; bus.pred_taken2 = 1'b1;
    step(); clr_in();
    check("taken1_ghr", 32'(bus.ghr_snapshot), 32'h03);
    check("taken1_idx1", 32'(bus.search_index1), 32'h003);
    check("taken1_idx2", 32'(bus.search_index2), 32'h002);

    // Mispredict repair beats same-cycle prediction
    resolve(32'h0000_0000, 8'h5A, 1'b1, 1'b1);
    bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b1;
    step(); clr_in();
    check("race_ghr", 32'(bus.ghr_snapshot), 32'hB5);
    check("race_idx1", 32'(bus.search_index1), 32'h0B5);
    check("race_cnt", bus.mispredict_cnt, 32'h1);
    check("race_cindex", 32'(bus.corr_index), 32'h05A);
    check("race_cflag", 32'(bus.corr_branch_flag), 32'h1);

    // Correct port uses fetch-time history, one cycle wide
    resolve(32'h0000_0400, 8'h0F, 1'b0, 1'b0);
    step(); clr_in();
    check("corr_valid", 32'(bus.corr_valid), 32'h1);
    check("corr_index", 32'(bus.corr_index), 32'h10F);
    check("corr_flag", 32'(bus.corr_branch_flag), 32'h0);
    check("corr_ghr_hold", 32'(bus.ghr_snapshot), 32'hB5);
    bus.pred_valid2 = 1'b1; bus.pred_taken2 = 1'b1;
    step(); clr_in();
    check("corr_pulse", 32'(bus.corr_valid), 32'h0);
    check("slot2_ghr", 32'(bus.ghr_snapshot), 32'h6B);

    // Fresh start for architectural history
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    resolve(32'h0, 8'h00, 1'b1, 1'b0); step();
    resolve(32'h0, 8'h00, 1'b0, 1'b0); step();
    resolve(32'h0, 8'h00, 1'b1, 1'b0); step(); clr_in();
    check("arch_spec_hold", 32'(bus.ghr_snapshot), 32'h00);
    for (int i = 0; i < 8; i++) begin
      bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b1;
      step();
    end
    clr_in();
    check("spec_ff", 32'(bus.ghr_snapshot), 32'hFF);

    // Flush restores arch history including the same-cycle resolve
    bus.flush = 1'b1;
    bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b1;
    resolve(32'h0000_0800, 8'hFF, 1'b1, 1'b0);
    step(); clr_in();
    check("flush_ghr", 32'(bus.ghr_snapshot), 32'h0B);
    check("flush_cvalid", 32'(bus.corr_valid), 32'h1);
    check("flush_cindex", 32'(bus.corr_index), 32'h2FF);

    // Flush beats mispredict repair, mispredict still counted
    bus.flush = 1'b1;
    resolve(32'h0, 8'h33, 1'b0, 1'b1);
    step(); clr_in();
    check("flush_mp_ghr", 32'(bus.ghr_snapshot), 32'h16);
    check("flush_mp_cnt", bus.mispredict_cnt, 32'h1);

    // Counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    resolve(32'h0, 8'h00, 1'b0, 1'b1);
    step();
    check("sat_cnt1", bus.mispredict_cnt, 32'hFFFF_FFFF);
    step(); clr_in();
    check("sat_cnt2", bus.mispredict_cnt, 32'hFFFF_FFFF);

    // Async reset mid-cycle with a resolve in flight; PC wrap on slot 2
    bus.fetch_pc = 32'hFFFF_FFFC;
    resolve(32'h0000_0400, 8'h0F, 1'b1, 1'b1);
    bus.pred_valid1 = 1'b1; bus.pred_taken1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ghr", 32'(bus.ghr_snapshot), 32'h00);
    check("arst_cnt", bus.mispredict_cnt, 32'h0);
    check("arst_cvalid", 32'(bus.corr_valid), 32'h0);
    check("wrap_idx1", 32'(bus.search_index1), 32'h3FF);
    check("wrap_idx2", 32'(bus.search_index2), 32'h000);
    @(negedge clk);
    check("arst_drop", 32'(bus.corr_valid), 32'h0);
    check("arst_cindex", 32'(bus.corr_index), 32'h000);
    rst_n = 1'b1;
    clr_in();
    step();
    check("post_rst_ghr", 32'(bus.ghr_snapshot), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_index_gen.md
Name: gshare_index_gen

Overview:
- Upstream neighbour of the PHT core in the IF branch unit.
- Keeps a speculative and an architectural global history register (GHR). Forms gshare indices (PC XOR GHR) for the two PHT search ports and the PHT correct port.
- Repairs speculative history on mispredict or flush.
- Registers the PHT correct-port outputs and counts mispredicts for performance monitoring.

Parameters:
- PHT_BITS, 10, PHT index width; must match the PHT core.
- GHR_BITS, 8, history length; legal range 1..PHT_BITS.
- PC_LSB, 2, lowest PC bit used in the index (word-aligned fetch).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- fetch_pc_i  in  32  PC of fetch slot 1; slot 2 is fetch_pc_i+4
- search_index1_o  out  PHT_BITS  PHT index for slot 1
- search_index2_o  out  PHT_BITS  PHT index for slot 2
- ghr_snapshot_o  out  GHR_BITS  speculative GHR used for this fetch; carried down the pipe with each branch
- pred_valid1_i  in  1  slot 1 holds a predicted conditional branch
- pred_taken1_i  in  1  prediction for slot 1
- pred_valid2_i  in  1  slot 2 holds a predicted conditional branch
- pred_taken2_i  in  1  prediction for slot 2
- ex_valid_i  in  1  a conditional branch resolved in EX (in program order)
- ex_pc_i  in  32  PC of the resolved branch
- ex_ghr_i  in  GHR_BITS  snapshot that travelled with that branch
- ex_taken_i  in  1  actual direction
- ex_mispredict_i  in  1  direction mispredicted; qualified by ex_valid_i
- flush_i  in  1  exception/ERET flush
- corr_valid_o  out  1  PHT correct-port valid
- corr_index_o  out  PHT_BITS  PHT correct-port index
- corr_branch_flag_o  out  1  PHT correct-port direction
- mispredict_cnt_o  out  32  saturating mispredict counter

Behaviour:
- Index hash: idx(pc,h) = pc[PC_LSB+PHT_BITS-1:PC_LSB] XOR zero-extended h, with h in the low bits.
- Search indices are combinational, with no added latency:
  - search_index1_o = idx(fetch_pc_i, spec_ghr).
  - search_index2_o = idx(fetch_pc_i+4, spec_ghr).
  - Both slots use the same history.
- ghr_snapshot_o = spec_ghr (combinational).
- spec_ghr update is registered. Evaluate in this priority order each cycle:
  1. flush_i=1: spec_ghr <= arch_next, where arch_next is arch_ghr including any same-cycle ex_valid_i shift.
  2. Else if ex_valid_i and ex_mispredict_i: spec_ghr <= {ex_ghr_i[GHR_BITS-2:0], ex_taken_i}. All same-cycle pred_* inputs are discarded.
  3. Else if pred_valid1_i and pred_taken1_i: shift in 1. Slot 2 is ignored because it is on the wrong path.
  4. Else if pred_valid1_i and pred_valid2_i: shift in {0, pred_taken2_i}, two bits, oldest first.
  5. Else if exactly one pred_valid*: shift in that slot's prediction.
  6. Else hold.
- GHR_BITS=1: every shift reduces to loading the newest bit.
- arch_ghr: on ex_valid_i, arch_ghr <= {arch_ghr[GHR_BITS-2:0], ex_taken_i}, regardless of flush_i. Otherwise hold.
- Correct port: registered, one-cycle latency from ex_valid_i:
  - corr_valid_o <= ex_valid_i.
  - corr_index_o <= idx(ex_pc_i, ex_ghr_i), using the fetch-time history, not the current history.
  - corr_branch_flag_o <= ex_taken_i.
  - The correct port is written even when flush_i is high.
- mispredict_cnt_o: increments on ex_valid_i and ex_mispredict_i, and saturates at 32'hFFFF_FFFF.
- Reset (rst=0, asynchronous, can assert mid-operation):
  - spec_ghr=0, arch_ghr=0.
  - corr_valid_o=0, corr_index_o=0, corr_branch_flag_o=0.
  - mispredict_cnt_o=0.
  - Search outputs then reflect idx(fetch_pc_i, 0).
  - Any in-flight correct update is dropped.
- PC wrap: fetch_pc_i+4 wraps modulo 2^32. Only index bits matter.

Decomposition:
- Shared package/header cpu.vh:
  - Existing RstEnable style macros.
  - Add `GHR_BITS` and `PHT_BITS` defaults so the PHT core and this block agree.
- One natural sub-module: gshare_hash, a purely combinational idx(pc,h), instantiated three times.
- Everything else stays flat.

Test Plan:
- Reset then fetch_pc_i=0x0000_1000 -> search_index1_o=0x000, search_index2_o=0x001, ghr_snapshot_o=0x00; all corr outputs 0.
- Cycle N: pred_valid1=1, pred_taken1=0, pred_valid2=1, pred_taken2=1 from GHR 0x00. Cycle N+1: pred_valid1=1, pred_taken1=1 -> GHR 0x01, then 0x03. With fetch_pc_i=0x1000, search_index1_o=0x003.
- Same-cycle race: ex_valid=1, ex_mispredict=1, ex_ghr=0x5A, ex_taken=1 together with pred_valid1=1, pred_taken1=1 -> spec_ghr=0xB5, and the pred input is ignored.
- ex_valid=1, ex_pc=0x0000_0400, ex_ghr=0x0F, ex_taken=0 -> next cycle corr_valid_o=1, corr_index_o=0x10F, corr_branch_flag_o=0, one cycle wide.
- Three resolves with taken=1,0,1 build arch_ghr=0x05; spec is pushed to 0xFF by predictions; then flush_i=1 in the same cycle as ex_valid=1, ex_taken=1 -> spec_ghr=0x0B.
- Force mispredict_cnt to 0xFFFF_FFFE and apply two mispredicts -> reads 0xFFFF_FFFF. Async reset mid-cycle -> all state 0 immediately.
